// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bundle: decode control, instruction-memory req/ack port and the IF/ID register outputs.
// Latency: none (signal container only).
// Backpressure: stall_d from decode and imem_ack from memory; master = fetch stage, slave = its environment.
interface if_fetch_stage_if;
    logic        stall_d;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc8_d;
    logic        valid_d;

    modport master (
        input  stall_d, redirect, redirect_pc, imem_ack, imem_rdata,
        output imem_req, imem_addr, instr_d, pc_d, pc8_d, valid_d
    );

    modport slave (
        output stall_d, redirect, redirect_pc, imem_ack, imem_rdata,
        input  imem_req, imem_addr, instr_d, pc_d, pc8_d, valid_d
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Fetch stage: owns PC and IF/ID, fetches over req/ack, applies decode redirects (DELAY_SLOT_EN keeps delay slot).
// Latency: ack in cycle N -> IF/ID updated at the edge ending N; 1 instr/cycle with ack tied to req.
// Backpressure: stall_d holds IF/ID and PC; an ack under stall parks the word in a 1-entry skid and drops req.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset_n,
    if_fetch_stage_if.master  bus
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_pc;
    logic        r_redir_pend;
    logic [31:0] r_redir_pc;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;
    logic [31:0] r_instr_d;
    logic [31:0] r_pc_d;
    logic [31:0] r_pc8_d;
    logic        r_valid_d;

    logic        w_complete;
    logic [31:0] w_cmp_instr;
    logic [31:0] w_cmp_pc;
    logic        w_skid_load;
    logic        w_bubble;
    logic        w_latch_redir;
    logic        w_taken;
    logic [31:0] w_target;
    logic [31:0] w_pc_nxt;
    logic        w_squash;

    // Next state and per-cycle events: completion, skid capture, bubble, redirect latch
    always_comb begin
        w_state_nxt   = r_state;
        w_complete    = 1'b0;
        w_cmp_instr   = bus.imem_rdata;
        w_cmp_pc      = r_pc;
        w_skid_load   = 1'b0;
        w_bubble      = 1'b0;
        w_latch_redir = 1'b0;
        case (r_state)
            S_BOOT: begin
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (bus.imem_ack) begin
                    if (bus.stall_d) begin
                        w_skid_load = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_complete = 1'b1;
                    end
                end else if (!bus.stall_d) begin
                    // request still in flight: never abandoned, so a redirect waits for its ack
                    w_bubble      = 1'b1;
                    w_latch_redir = bus.redirect;
                end
            end
            S_HOLD: begin
                if (!bus.stall_d) begin
                    w_complete  = 1'b1;
                    w_cmp_instr = r_skid_instr;
                    w_cmp_pc    = r_skid_pc;
                    w_state_nxt = S_REQ;
                end
            end
            default: begin
                w_state_nxt = S_BOOT;
            end
        endcase
    end

    // A completion only happens with stall_d=0, so a redirect seen here is always honoured;
    // a live redirect overrides an older latched one.
    assign w_taken  = w_complete & (bus.redirect | r_redir_pend);
    assign w_target = bus.redirect ? bus.redirect_pc : r_redir_pc;
    assign w_pc_nxt = w_taken ? w_target : (w_cmp_pc + 32'd4);

`ifdef DELAY_SLOT_EN
    assign w_squash = 1'b0;
`else
    assign w_squash = w_taken;
`endif

    assign bus.imem_req  = (r_state == S_REQ);
    assign bus.imem_addr = r_pc;
    assign bus.instr_d   = r_instr_d;
    assign bus.pc_d      = r_pc_d;
    assign bus.pc8_d     = r_pc8_d;
    assign bus.valid_d   = r_valid_d;

    // FSM state register; async reset drops imem_req immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // PC advance and pending-redirect bookkeeping
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc         <= RESET_PC;
            r_redir_pend <= 1'b0;
            r_redir_pc   <= RESET_PC;
        end else begin
            if (w_complete) begin
                r_pc         <= w_pc_nxt;
                r_redir_pend <= 1'b0;
            end else if (w_latch_redir) begin
                r_redir_pend <= 1'b1;
                r_redir_pc   <= bus.redirect_pc;
            end
        end
    end

    // Skid buffer: parks the word acked while decode is stalled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= RESET_PC;
        end else if (w_skid_load) begin
            r_skid_instr <= bus.imem_rdata;
            r_skid_pc    <= r_pc;
        end
    end

    // IF/ID register: real instruction, bubble (pc fields hold), or hold under stall
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_instr_d <= NOP_INSTR;
            r_pc_d    <= RESET_PC;
            r_pc8_d   <= RESET_PC + 32'd8;
            r_valid_d <= 1'b0;
        end else if (w_complete && !w_squash) begin
            r_instr_d <= w_cmp_instr;
            r_pc_d    <= w_cmp_pc;
            r_pc8_d   <= w_cmp_pc + 32'd8;
            r_valid_d <= 1'b1;
        end else if (w_bubble || (w_complete && w_squash)) begin
            r_instr_d <= NOP_INSTR;
            r_valid_d <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios with literal expectations, then randomized traffic vs a reference model.
// Latency: outputs checked on the falling edge after each rising edge.
// Backpressure: bench drives stall_d and imem_ack; ack is only offered while a fetch is expected.
module tb_if_fetch_stage;

    localparam logic [31:0] RST = 32'h0000_3000;
    localparam logic [31:0] NOP = 32'h0000_0000;
`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    if_fetch_stage_if bus ();

    if_fetch_stage #(.RESET_PC(RST), .NOP_INSTR(NOP)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // instruction memory: word is a fixed hash of the address
    always_comb bus.imem_rdata = mem_word(bus.imem_addr);

    // ---------------- reference model (instruction-level view) ----------------
    bit          m_boot;
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_pend_pc;
    bit          m_held;
    logic [31:0] m_held_w, m_held_pc;
    logic [31:0] m_instr, m_pcd;
    bit          m_valid;

    task automatic model_reset();
        m_boot = 1; m_pc = RST; m_pend = 0; m_pend_pc = RST; m_held = 0;
        m_held_w = NOP; m_held_pc = RST; m_instr = NOP; m_pcd = RST; m_valid = 0;
    endtask

    // instruction at p with word w retires into IF/ID; PC moves on
    task automatic model_complete(input logic [31:0] w, p, input bit r, input logic [31:0] rp);
        bit          taken;
        logic [31:0] tgt;
        taken = r || m_pend;
        tgt   = r ? rp : m_pend_pc;
        m_pend = 0;
        if (taken && !DS) begin
            m_instr = NOP; m_valid = 0;
        end else begin
            m_instr = w; m_pcd = p; m_valid = 1;
        end
        m_pc = taken ? tgt : p + 32'd4;
    endtask

    task automatic model_step(input bit a, s, r, input logic [31:0] rp);
        if (m_boot) begin
            m_boot = 0;
        end else if (m_held) begin
            if (!s) begin
                m_held = 0;
                model_complete(m_held_w, m_held_pc, r, rp);
            end
        end else if (a) begin
            if (s) begin
                m_held = 1; m_held_w = mem_word(m_pc); m_held_pc = m_pc;
            end else begin
                model_complete(mem_word(m_pc), m_pc, r, rp);
            end
        end else if (!s) begin
            m_instr = NOP; m_valid = 0;
            if (r) begin m_pend = 1; m_pend_pc = rp; end
        end
    endtask

    // apply one cycle of inputs (at a falling edge), advance model, land on next falling edge
    task automatic cyc(input bit a, s, r, input logic [31:0] rp);
        bus.imem_ack = a; bus.stall_d = s; bus.redirect = r; bus.redirect_pc = rp;
        model_step(a, s, r, rp);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bus.imem_ack = 0; bus.stall_d = 0; bus.redirect = 0; bus.redirect_pc = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        cyc(0, 0, 0, '0);
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        bus.imem_ack = 0; bus.stall_d = 0; bus.redirect = 0; bus.redirect_pc = '0;
        repeat (2) @(negedge clk);
        n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", bus.imem_req); end
        n_tests++; if (bus.instr_d !== NOP) begin n_fail++; $display("FAIL rst_instr: got %h want %h", bus.instr_d, NOP); end
        n_tests++; if (bus.pc_d !== RST) begin n_fail++; $display("FAIL rst_pc_d: got %h want %h", bus.pc_d, RST); end
        n_tests++; if (bus.pc8_d !== RST + 32'd8) begin n_fail++; $display("FAIL rst_pc8_d: got %h want %h", bus.pc8_d, RST + 32'd8); end
        n_tests++; if (bus.valid_d !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.valid_d); end
        reset_n = 1'b1;
        model_reset();
        n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL boot_req: got %b want 0", bus.imem_req); end
        cyc(0, 0, 0, '0);
        n_tests++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b want 1", bus.imem_req); end
        n_tests++; if (bus.imem_addr !== RST) begin n_fail++; $display("FAIL first_addr: got %h want %h", bus.imem_addr, RST); end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            a = RST + 32'(4 * i);
            n_tests++; if (bus.imem_addr !== a) begin n_fail++; $display("FAIL seq_addr%0d: got %h want %h", i, bus.imem_addr, a); end
            cyc(1, 0, 0, '0);
            n_tests++; if (bus.instr_d !== mem_word(a)) begin n_fail++; $display("FAIL seq_instr%0d: got %h want %h", i, bus.instr_d, mem_word(a)); end
            n_tests++; if (bus.pc8_d !== a + 32'd8) begin n_fail++; $display("FAIL seq_pc8%0d: got %h want %h", i, bus.pc8_d, a + 32'd8); end
            n_tests++; if (bus.valid_d !== 1'b1) begin n_fail++; $display("FAIL seq_valid%0d: got %b want 1", i, bus.valid_d); end
        end
    endtask

    task automatic test_ack_delay();
        do_reset();
        cyc(1, 0, 0, '0);
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, '0);
            n_tests++; if (bus.imem_addr !== 32'h3004) begin n_fail++; $display("FAIL dly_addr%0d: got %h want 00003004", i, bus.imem_addr); end
            n_tests++; if (bus.valid_d !== 1'b0 || bus.instr_d !== NOP) begin n_fail++; $display("FAIL dly_bubble%0d: got v=%b i=%h want v=0 i=%h", i, bus.valid_d, bus.instr_d, NOP); end
            n_tests++; if (bus.pc_d !== RST) begin n_fail++; $display("FAIL dly_pcd%0d: got %h want %h", i, bus.pc_d, RST); end
        end
        cyc(1, 0, 0, '0);
        n_tests++; if (bus.instr_d !== mem_word(32'h3004)) begin n_fail++; $display("FAIL dly_instr: got %h want %h", bus.instr_d, mem_word(32'h3004)); end
        n_tests++; if (bus.imem_addr !== 32'h3008) begin n_fail++; $display("FAIL dly_next: got %h want 00003008", bus.imem_addr); end
    endtask

    task automatic test_stall();
        do_reset();
        cyc(1, 0, 0, '0);
        cyc(1, 0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            cyc(i == 0, 1, 0, '0);
            n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req%0d: got %b want 0", i, bus.imem_req); end
            n_tests++; if (bus.instr_d !== mem_word(32'h3004)) begin n_fail++; $display("FAIL stall_instr%0d: got %h want %h", i, bus.instr_d, mem_word(32'h3004)); end
        end
        cyc(0, 0, 0, '0);
        n_tests++; if (bus.instr_d !== mem_word(32'h3008)) begin n_fail++; $display("FAIL rel_instr: got %h want %h", bus.instr_d, mem_word(32'h3008)); end
        n_tests++; if (bus.pc_d !== 32'h3008) begin n_fail++; $display("FAIL rel_pcd: got %h want 00003008", bus.pc_d); end
        n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h300C) begin n_fail++; $display("FAIL rel_fetch: got req=%b addr=%h want req=1 addr=0000300c", bus.imem_req, bus.imem_addr); end
    endtask

    task automatic test_redirect();
        logic [31:0] want_i, want_p;
        do_reset();
        repeat (4) cyc(1, 0, 0, '0);
        cyc(0, 0, 1, 32'h3100);
        n_tests++; if (bus.imem_addr !== 32'h3010) begin n_fail++; $display("FAIL rdr_inflight: got %h want 00003010", bus.imem_addr); end
        cyc(1, 0, 0, '0);
        want_i = DS ? mem_word(32'h3010) : NOP;
        want_p = DS ? 32'h3010 : 32'h300C;
        n_tests++; if (bus.imem_addr !== 32'h3100) begin n_fail++; $display("FAIL rdr_target: got %h want 00003100", bus.imem_addr); end
        n_tests++; if (bus.instr_d !== want_i) begin n_fail++; $display("FAIL rdr_slot_instr: got %h want %h", bus.instr_d, want_i); end
        n_tests++; if (bus.valid_d !== DS) begin n_fail++; $display("FAIL rdr_slot_valid: got %b want %b", bus.valid_d, DS); end
        n_tests++; if (bus.pc_d !== want_p) begin n_fail++; $display("FAIL rdr_slot_pcd: got %h want %h", bus.pc_d, want_p); end
        cyc(1, 0, 0, '0);
        n_tests++; if (bus.instr_d !== mem_word(32'h3100) || bus.pc_d !== 32'h3100) begin n_fail++; $display("FAIL rdr_tgt_instr: got %h@%h want %h@00003100", bus.instr_d, bus.pc_d, mem_word(32'h3100)); end
        cyc(1, 0, 1, 32'h3200);
        n_tests++; if (bus.imem_addr !== 32'h3200) begin n_fail++; $display("FAIL rdr_same_cycle: got %h want 00003200", bus.imem_addr); end
    endtask

    task automatic test_redirect_stalled();
        do_reset();
        cyc(1, 0, 0, '0);
        cyc(0, 1, 1, 32'h3300);
        cyc(1, 0, 0, '0);
        n_tests++; if (bus.imem_addr !== 32'h3008) begin n_fail++; $display("FAIL rstl_addr: got %h want 00003008", bus.imem_addr); end
        n_tests++; if (bus.instr_d !== mem_word(32'h3004) || bus.valid_d !== 1'b1) begin n_fail++; $display("FAIL rstl_instr: got %h v=%b want %h v=1", bus.instr_d, bus.valid_d, mem_word(32'h3004)); end
        cyc(1, 1, 1, 32'h3300);
        cyc(0, 0, 0, '0);
        n_tests++; if (bus.imem_addr !== 32'h300C) begin n_fail++; $display("FAIL rstl_hold_addr: got %h want 0000300c", bus.imem_addr); end
        n_tests++; if (bus.instr_d !== mem_word(32'h3008)) begin n_fail++; $display("FAIL rstl_hold_instr: got %h want %h", bus.instr_d, mem_word(32'h3008)); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(1, 0, 0, '0);
        cyc(0, 0, 0, '0);
        bus.imem_ack = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL mid_req: got %b want 0", bus.imem_req); end
        n_tests++; if (bus.imem_addr !== RST) begin n_fail++; $display("FAIL mid_addr: got %h want %h", bus.imem_addr, RST); end
        n_tests++; if (bus.instr_d !== NOP || bus.valid_d !== 1'b0) begin n_fail++; $display("FAIL mid_ifid: got %h v=%b want %h v=0", bus.instr_d, bus.valid_d, NOP); end
        n_tests++; if (bus.pc_d !== RST || bus.pc8_d !== RST + 32'd8) begin n_fail++; $display("FAIL mid_pcd: got %h/%h want %h/%h", bus.pc_d, bus.pc8_d, RST, RST + 32'd8); end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        cyc(0, 0, 0, '0);
        n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST) begin n_fail++; $display("FAIL mid_restart: got req=%b addr=%h want req=1 addr=%h", bus.imem_req, bus.imem_addr, RST); end
    endtask

    // ---------------- randomized traffic vs model ----------------
    task automatic test_random();
        bit          a, s, r;
        logic [31:0] t;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            n_tests++; if (bus.imem_req !== (!m_boot && !m_held)) begin n_fail++; $display("FAIL rnd_req@%0d: got %b want %b", i, bus.imem_req, !m_boot && !m_held); end
            n_tests++; if (bus.imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr@%0d: got %h want %h", i, bus.imem_addr, m_pc); end
            n_tests++; if (bus.instr_d !== m_instr) begin n_fail++; $display("FAIL rnd_instr@%0d: got %h want %h", i, bus.instr_d, m_instr); end
            n_tests++; if (bus.valid_d !== m_valid) begin n_fail++; $display("FAIL rnd_valid@%0d: got %b want %b", i, bus.valid_d, m_valid); end
            n_tests++; if (bus.pc_d !== m_pcd) begin n_fail++; $display("FAIL rnd_pcd@%0d: got %h want %h", i, bus.pc_d, m_pcd); end
            n_tests++; if (bus.pc8_d !== m_pcd + 32'd8) begin n_fail++; $display("FAIL rnd_pc8@%0d: got %h want %h", i, bus.pc8_d, m_pcd + 32'd8); end
            a = (!m_boot && !m_held) && ($urandom_range(0, 9) < 6);
            s = ($urandom_range(0, 9) < 3);
            r = ($urandom_range(0, 9) == 0);
            t = $urandom();
            t[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF8;
            cyc(a, s, r, t);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_ack_delay();
        test_stall();
        test_redirect();
        test_redirect_stalled();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
